// File: rtl/input_event_pkg.sv
// Shared types and constants for the input event collector.
// Entry layout is {tag, payload}.
package input_event_pkg;

  localparam int EV_DATA_W   = 16;
  localparam int EV_MAX_CH   = 8;
  localparam int EV_TAG_W    = $clog2(EV_MAX_CH);

  localparam int EV_CH_KBD   = 0;
  localparam int EV_CH_MOUSE = 1;
  localparam int EV_CH_USB   = 2;

  typedef logic [EV_TAG_W-1:0] ev_tag_t;

  typedef struct packed {
    ev_tag_t              tag;
    logic [EV_DATA_W-1:0] payload;
  } ev_entry_t;

  // Round-robin candidate: channel `step` places after `last`.
  function automatic int rr_next(int last, int step, int n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO with extended-pointer full/empty.
// A pop frees the slot the same-cycle push needs when full.
module event_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = wptr - rptr;
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/input_event_queue.sv
// Multi-channel event collector: per-channel holding registers,
// round-robin merge into a tagged show-ahead FIFO.
module input_event_queue
  import input_event_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int TAG_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ev_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] ev_data_i,
  output logic                     rd_valid_o,
  output logic [TAG_W+DATA_W-1:0]  rd_data_o,
  input  logic                     rd_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [NUM_CH-1:0]        overflow_o,
  input  logic                     clr_overflow_i
);

  logic [NUM_CH-1:0] pend;
  logic [DATA_W-1:0] hold [NUM_CH];
  logic [TAG_W-1:0]  last;

  logic              full;
  logic              empty;
  logic              pop;
  logic              push_ok;
  logic              gnt_any;
  logic              grant;
  logic [TAG_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] gnt_data;
  logic [NUM_CH-1:0] take;
  logic [NUM_CH-1:0] drop;

  assign rd_valid_o = !empty;
  assign pop        = rd_valid_o && rd_ready_i;
  assign push_ok    = !full || pop;
  assign grant      = gnt_any && push_ok;

  always_comb begin : arb
    int c;
    c        = 0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = rr_next(int'(last), i, NUM_CH);
      if (!gnt_any && pend[c]) begin
        gnt_any  = 1'b1;
        gnt_idx  = TAG_W'(c);
        gnt_data = hold[c];
      end
    end
  end

  always_comb begin
    take = '0;
    drop = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      take[k] = grant && (gnt_idx == TAG_W'(k));
      drop[k] = ev_valid_i[k] && pend[k] && !take[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= '0;
      overflow_o <= '0;
      last       <= TAG_W'(NUM_CH - 1);
      for (int k = 0; k < NUM_CH; k++) hold[k] <= '0;
    end else begin
      if (grant) last <= gnt_idx;
      // A drop in the clear cycle still leaves its flag set.
      overflow_o <= (clr_overflow_i ? '0 : overflow_o) | drop;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ev_valid_i[k] && (!pend[k] || take[k]))
          hold[k] <= ev_data_i[k*DATA_W +: DATA_W];
        if (take[k])
          pend[k] <= ev_valid_i[k];
        else if (ev_valid_i[k])
          pend[k] <= 1'b1;
      end
    end
  end

  event_fifo #(
    .WIDTH(TAG_W + DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (grant),
    .wdata({gnt_idx, gnt_data}),
    .pop  (rd_ready_i),
    .rdata(rd_data_o),
    .full (full),
    .empty(empty),
    .count(count_o)
  );

endmodule

// File: tb/tb_input_event_queue.sv
// Directed bench for input_event_queue with a queue-based reference
// model compared every cycle plus literal checkpoints.
module tb_input_event_queue;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int TAG_W  = 2;
  localparam int EW     = TAG_W + DATA_W;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH-1:0]        ev_valid;
  logic [NUM_CH*DATA_W-1:0] ev_data;
  logic                     rd_valid;
  logic [EW-1:0]            rd_data;
  logic                     rd_ready;
  logic [4:0]               count;
  logic [NUM_CH-1:0]        overflow;
  logic                     clr;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  input_event_queue #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ev_valid_i    (ev_valid),
    .ev_data_i     (ev_data),
    .rd_valid_o    (rd_valid),
    .rd_data_o     (rd_data),
    .rd_ready_i    (rd_ready),
    .count_o       (count),
    .overflow_o    (overflow),
    .clr_overflow_i(clr)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of tagged entries, one optional
  // pending payload per channel, and a round-robin pointer.
  logic [EW-1:0]     q[$];
  logic [DATA_W-1:0] m_hold [NUM_CH];
  logic [NUM_CH-1:0] m_pend;
  logic [NUM_CH-1:0] m_ovf;
  int                m_last;
  bit                m_pop;
  int                m_g;

  initial begin
    m_pend = '0;
    m_ovf  = '0;
    m_last = NUM_CH - 1;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        m_pend = '0;
        m_ovf  = '0;
        m_last = NUM_CH - 1;
      end else begin
        m_pop = (q.size() != 0) && rd_ready;
        m_g   = -1;
        if (q.size() < DEPTH || m_pop)
          for (int i = 1; i <= NUM_CH; i++)
            if (m_g < 0 && m_pend[(m_last + i) % NUM_CH])
              m_g = (m_last + i) % NUM_CH;
        if (m_pop) void'(q.pop_front());
        if (m_g >= 0) begin
          q.push_back({TAG_W'(m_g), m_hold[m_g]});
          m_pend[m_g] = 1'b0;
          m_last = m_g;
        end
        if (clr) m_ovf = '0;
        for (int k = 0; k < NUM_CH; k++)
          if (ev_valid[k]) begin
            if (m_pend[k]) m_ovf[k] = 1'b1;
            else begin
              m_hold[k] = ev_data[k*DATA_W +: DATA_W];
              m_pend[k] = 1'b1;
            end
          end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("model_valid", 32'(rd_valid), 32'(q.size() != 0));
      chk("model_data", 32'(rd_data),
          (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("model_count", 32'(count), 32'(q.size()));
      chk("model_ovf", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic strobe(input int ch, input logic [15:0] d);
    ev_valid = '0;
    ev_valid[ch] = 1'b1;
    ev_data[ch*DATA_W +: DATA_W] = d;
    @(negedge clk);
    ev_valid = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1; ev_valid = '0; ev_data = '0;
    rd_ready = 0; clr = 0;
    cyc(3);
    reset = 0;
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk_en = 1;

    // Simultaneous strobes, drained as they arrive
    rd_ready = 1;
    ev_data = {16'h000C, 16'h000B, 16'h000A};
    ev_valid = 3'b111;
    cyc(1);
    ev_valid = '0;
    cyc(1);
    chk("sim_0", 32'(rd_data), 32'h0000A);
    cyc(1);
    chk("sim_1", 32'(rd_data), 32'h1000B);
    cyc(1);
    chk("sim_2", 32'(rd_data), 32'h2000C);
    chk("sim_ovf", 32'(overflow), 0);
    cyc(1);
    chk("sim_empty", 32'(rd_valid), 0);
    rd_ready = 0;

    // Single event latency
    strobe(0, 16'h001C);
    chk("lat_n1", 32'(rd_valid), 0);
    cyc(1);
    chk("lat_n2", 32'(rd_valid), 1);
    chk("single_data", 32'(rd_data), 32'h0001C);
    chk("single_cnt", 32'(count), 1);
    rd_ready = 1;
    cyc(1);
    rd_ready = 0;
    chk("single_pop", 32'(count), 0);

    // Fill with 17 ch1 events; the last one stays held
    for (int i = 0; i < 17; i++) begin
      strobe(1, 16'h0100 + 16'(i));
      cyc(2);
    end
    chk("fill_cnt", 32'(count), 16);
    chk("fill_ovf0", 32'(overflow), 0);
    strobe(1, 16'h01FF);
    chk("ovf_set", 32'(overflow), 32'b010);
    ev_valid[1] = 1;
    clr = 1;
    cyc(1);
    ev_valid = '0;
    clr = 0;
    chk("ovf_clr_race", 32'(overflow), 32'b010);
    clr = 1;
    cyc(1);
    clr = 0;
    chk("ovf_clr", 32'(overflow), 0);
    rd_ready = 1;
    cyc(1);
    rd_ready = 0;
    chk("popfull_cnt", 32'(count), 16);
    chk("popfull_head", 32'(rd_data), 32'h10101);

    // Full with ch2 pending: push and pop together
    strobe(2, 16'h0200);
    cyc(1);
    chk("ch2_wait", 32'(count), 16);
    rd_ready = 1;
    cyc(1);
    rd_ready = 0;
    chk("pushpop_cnt", 32'(count), 16);
    rd_ready = 1;
    cyc(18);
    rd_ready = 0;
    chk("drain_cnt", 32'(count), 0);

    // Grant/reload collision on ch0
    ev_valid = 3'b001;
    ev_data[15:0] = 16'h0011;
    cyc(1);
    ev_data[15:0] = 16'h0022;
    cyc(1);
    ev_valid = '0;
    cyc(1);
    chk("coll_cnt", 32'(count), 2);
    chk("coll_first", 32'(rd_data), 32'h00011);
    chk("coll_ovf", 32'(overflow), 0);
    rd_ready = 1;
    cyc(1);
    rd_ready = 0;
    chk("coll_second", 32'(rd_data), 32'h00022);
    chk("coll_cnt2", 32'(count), 1);
    rd_ready = 1;
    cyc(1);
    rd_ready = 0;

    // Reset mid-stream
    for (int i = 0; i < 5; i++) strobe(0, 16'h0300 + 16'(i));
    strobe(1, 16'h0400);
    reset = 1;
    cyc(1);
    chk("mrst_valid", 32'(rd_valid), 0);
    chk("mrst_cnt", 32'(count), 0);
    cyc(1);
    reset = 0;
    chk("mrst_data", 32'(rd_data), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    cyc(1);
    chk("mrst_idle", 32'(rd_valid), 0);
    strobe(2, 16'h0C0C);
    cyc(1);
    chk("mrst_first", 32'(rd_data), 32'h20C0C);
    chk("mrst_first_cnt", 32'(count), 1);
    rd_ready = 1;
    cyc(2);
    rd_ready = 0;
    chk("end_cnt", 32'(count), 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_event_queue.md
# input_event_queue

Parametrised multi-channel input event collector between the peripheral decoders (PS/2 keyboard, PS/2 mouse, USB HID) and the SoC register bus. It accepts single-cycle event strobes from `NUM_CH` channels, buffers one event per channel, and merges them round-robin into a tagged FIFO. The CPU drains the FIFO through a valid/ready port. Unlike direct strobe wiring, it loses no simultaneous events and records per-channel overflow.

## Interface
- `NUM_CH`, 3: number of event channels, 2..8.
- `DATA_W`, 16: payload width per event.
- `DEPTH`, 16: FIFO entries, power of 2, ≥ 2.
- `TAG_W`, `$clog2(NUM_CH)`: derived width of the channel tag.

- `clk`  in  1  system clock. Single clock domain; all inputs are synchronous to `clk`.
- `reset`  in  1  asynchronous, active-high reset.
- `ev_valid_i`  in  NUM_CH  per-channel event strobe, one cycle per event.
- `ev_data_i`  in  NUM_CH*DATA_W  payloads; channel k occupies bits [k*DATA_W +: DATA_W].
- `rd_valid_o`  out  1  FIFO non-empty.
- `rd_data_o`  out  TAG_W+DATA_W  {tag, payload} of the head entry.
- `rd_ready_i`  in  1  consumer accepts the head entry.
- `count_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow_o`  out  NUM_CH  sticky per-channel drop flag.
- `clr_overflow_i`  in  1  clears all overflow flags.

## Operation
- Per-channel holding register (`pend[k]`, `hold[k]`):
  - `ev_valid_i[k]` with `pend[k]`=0: latch the payload and set `pend[k]`.
  - `ev_valid_i[k]` with `pend[k]`=1 and channel k not granted this cycle: drop the new event and set `overflow_o[k]`.
  - `ev_valid_i[k]` in the same cycle channel k is granted: the new payload replaces the granted one and `pend[k]` stays 1. No drop.
- Arbiter:
  - Combinational round-robin over `pend`. Search starts at `last+1` (mod `NUM_CH`).
  - `last` resets to `NUM_CH-1`, so channel 0 has first priority after reset.
  - Grant only when `push_ok` = !full || (rd_valid_o && rd_ready_i).
  - On grant: push {k, hold[k]}, clear `pend[k]` (unless reloaded as above), `last`<=k.
  - At most one push per cycle.
- FIFO:
  - Register-array FIFO with read/write pointers of $clog2(DEPTH)+1 bits; full/empty derived from the MSB compare.
  - Head is presented combinationally from the array (show-ahead).
  - Pop occurs when rd_valid_o && rd_ready_i.
  - When full, a push and a pop may happen in the same cycle; count is unchanged.
- Overflow flags:
  - `clr_overflow_i` clears all flags.
  - A drop in the same cycle as the clear wins: the flag stays set.
- Pending events wait indefinitely while the FIFO is full. Nothing is dropped at the FIFO.

## Timing
- Reset values: `rd_valid_o`=0, `rd_data_o`=0, `count_o`=0, `overflow_o`=0. All `pend`=0, `last`=NUM_CH-1, pointers=0.
- Reset is asynchronous at assertion and is sampled at the first `clk` edge after release. Assertion mid-operation discards all pending and queued events.
- Latency: an event strobed in cycle n is held in cycle n+1, pushed at the end of n+1, and seen as `rd_valid_o`=1 in cycle n+2 when the FIFO was empty and no other channel wins arbitration.
- Throughput: one push and one pop per cycle.
- `count_o` updates one cycle after the push or pop edge: +1 on push only, -1 on pop only, 0 on both.
- `rd_data_o` is stable while `rd_valid_o`=1 and `rd_ready_i`=0.

## Structure
- Package `input_event_pkg`:
  - `ev_tag_t` and `ev_entry_t` (packed {tag, payload}), parametrised via localparams `EV_DATA_W`=16 and `EV_MAX_CH`=8.
  - Channel index constants: `EV_CH_KBD`=0, `EV_CH_MOUSE`=1, `EV_CH_USB`=2.
- Sub-module `event_fifo`: a synchronous show-ahead FIFO with params WIDTH and DEPTH, push/pop/full/empty/count. Holding registers and the arbiter stay in the top module.

## Test plan
- Single event: ch0 `ev_valid_i`=1 with data 0x001C in cycle 10 → `rd_valid_o`=1 in cycle 12, `rd_data_o`={0,0x001C}, `count_o`=1. Pop → `count_o`=0 the next cycle.
- Simultaneous events: ch0/ch1/ch2 strobe 0x0A/0x0B/0x0C in the same cycle, `rd_ready_i`=1 → outputs {0,0x0A}, {1,0x0B}, {2,0x0C} on consecutive cycles. `overflow_o`=0.
- Fill and overflow: `rd_ready_i`=0, 17 ch1 events spaced 3 cycles apart → `count_o`=16, ch1 pending, 17th event held. An 18th ch1 strobe → `overflow_o[1]`=1. Single pop → held event enters, `count_o` stays 16.
- Full push+pop: FIFO full with ch2 pending, `rd_ready_i`=1 for one cycle → head popped, ch2 entry pushed in the same cycle, `count_o`=16.
- Grant/reload collision: ch0 pending with 0x11, new ch0 strobe 0x22 in the grant cycle → FIFO receives 0x11, then 0x22. No overflow.
- Reset mid-stream: 5 entries queued, ch1 pending, `reset` pulsed → all outputs return to reset values. The next ch2 event is first out with tag 2.
